// File: rtl/mdio_pkg.sv
// mdio_pkg: clause-22 MDIO frame constants and master state encoding
package mdio_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HDR, TA, DATA, IDLE_BIT} mdio_state_t;
  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam int MDIO_HDR_BITS  = 14;
  localparam int MDIO_DATA_BITS = 16;
endpackage

// File: rtl/mdio_master_if.sv
// mdio_master_if: register request/response channel between a configuration controller and the MDIO master
interface mdio_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy_addr;
  logic [4:0]  req_reg_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  modport master (
    output req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );
  modport slave (
    input  req_valid, req_write, req_phy_addr, req_reg_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mdc_clock_gen.sv
// mdc_clock_gen: MDC divider with one-cycle rise/fall strobes, parked low while disabled
module mdc_clock_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] TOP = W'(CLK_DIV - 1);
  logic [W-1:0] cnt;
  logic wrap;
  assign wrap = en && cnt == TOP;
  assign rise = wrap && !mdc;
  assign fall = wrap && mdc;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= (wrap || !en) ? '0 : cnt + 1'b1;
      mdc <= en && (wrap ? !mdc : mdc);
    end
endmodule

// File: rtl/mdio_master.sv
// mdio_master: serialises single clause-22 register reads/writes onto MDC/MDIO and returns read data
module mdio_master import mdio_pkg::*; #(
  parameter int CLK_DIV      = 50,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic clock,
  input  logic reset_n,
  mdio_master_if.slave bus,
  output logic mdc,
  output logic mdio_o,
  output logic mdio_oe,
  input  logic mdio_i
);
  mdio_state_t state, state_n;
  logic [5:0]  bcnt, bcnt_n;
  logic [31:0] sreg, sreg_n, frame;
  logic [15:0] rdata, rdata_n;
  logic        wr_q, wr_n, err, err_n, mdo_n, oe_n;
  logic        rise, fall, accept, shift;

  function automatic logic [5:0] bits_of(mdio_state_t s);
    return s == PREAMBLE ? 6'(PREAMBLE_LEN - 1) :
           s == HDR      ? 6'(MDIO_HDR_BITS - 1) :
           s == TA       ? 6'd1 :
           s == DATA     ? 6'(MDIO_DATA_BITS - 1) : 6'd0;
  endfunction

  function automatic mdio_state_t succ(mdio_state_t s);
    return s == PREAMBLE ? HDR : s == HDR ? TA : s == TA ? DATA : s == DATA ? IDLE_BIT : IDLE;
  endfunction

  mdc_clock_gen #(.CLK_DIV(CLK_DIV)) u_mdc (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (state != IDLE),
    .mdc    (mdc),
    .rise   (rise),
    .fall   (fall)
  );

  // completion is the falling edge that closes IDLE_BIT, so a new request can start on that very edge
  assign bus.rsp_valid = state == IDLE_BIT && fall && bcnt == 6'd0;
  assign bus.req_ready = state == IDLE || bus.rsp_valid;
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_error = err;
  assign accept = bus.req_valid && bus.req_ready;
  assign frame  = {MDIO_ST, bus.req_write ? MDIO_OP_WR : MDIO_OP_RD, bus.req_phy_addr,
                   bus.req_reg_addr, 2'b10, bus.req_wdata};

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    sreg_n  = sreg;
    wr_n    = wr_q;
    rdata_n = rdata;
    err_n   = err;
    mdo_n   = mdio_o;
    oe_n    = mdio_oe;
    shift   = 1'b0;
    if (rise && !wr_q) begin
      err_n   = (state == TA && bcnt == 6'd0) ? mdio_i : err;
      rdata_n = state == DATA ? {rdata[14:0], mdio_i} : rdata;
    end
    if (accept) begin
      state_n = PREAMBLE_LEN == 0 ? HDR : PREAMBLE;
      bcnt_n  = bits_of(state_n);
      wr_n    = bus.req_write;
      rdata_n = '0;
      err_n   = 1'b0;
      oe_n    = 1'b1;
      mdo_n   = PREAMBLE_LEN == 0 ? frame[31] : 1'b1;
      sreg_n  = PREAMBLE_LEN == 0 ? frame << 1 : frame;
    end else if (fall) begin
      state_n = bcnt == 6'd0 ? succ(state) : state;
      bcnt_n  = bcnt == 6'd0 ? bits_of(state_n) : bcnt - 1'b1;
      shift   = state_n == HDR || state_n == TA || state_n == DATA;
      mdo_n   = shift ? sreg[31] : 1'b1;
      sreg_n  = shift ? sreg << 1 : sreg;
      oe_n    = state_n == PREAMBLE || state_n == HDR || (wr_q && shift);
    end
  end

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      bcnt    <= '0;
      sreg    <= '0;
      wr_q    <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      mdio_o  <= 1'b1;
      mdio_oe <= 1'b0;
    end else begin
      state   <= state_n;
      bcnt    <= bcnt_n;
      sreg    <= sreg_n;
      wr_q    <= wr_n;
      rdata   <= rdata_n;
      err     <= err_n;
      mdio_o  <= mdo_n;
      mdio_oe <= oe_n;
    end
endmodule
